// File: rtl/line_queue.sv
// line_queue: first-word-fall-through segment FIFO plus frame sequencer feeding the line-draw engine.
// Define LINE_QUEUE_CLIP_EN to clamp pushed endpoints to the screen area.
module line_queue #(
  parameter int P_X_COORD_W  = 11,
  parameter int P_Y_COORD_W  = 11,
  parameter int P_LOG2_DEPTH = 4,
  parameter int P_SCREEN_W   = 640,
  parameter int P_SCREEN_H   = 480
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_wr,
  input  logic [P_X_COORD_W-1:0]   i_x0,
  input  logic [P_Y_COORD_W-1:0]   i_y0,
  input  logic [P_X_COORD_W-1:0]   i_x1,
  input  logic [P_Y_COORD_W-1:0]   i_y1,
  input  logic                     i_frame_end,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [P_LOG2_DEPTH:0]    o_count,
  output logic [P_X_COORD_W-1:0]   o_x0,
  output logic [P_Y_COORD_W-1:0]   o_y0,
  output logic [P_X_COORD_W-1:0]   o_x1,
  output logic [P_Y_COORD_W-1:0]   o_y1,
  input  logic                     i_pop,
  input  logic                     i_draw_waiting,
  output logic                     o_clear_buffer,
  output logic                     o_overflow
);

  localparam int DEPTH = 1 << P_LOG2_DEPTH;
  localparam int SEG_W = 2 * P_X_COORD_W + 2 * P_Y_COORD_W;
  localparam logic [P_LOG2_DEPTH:0] COUNT_FULL = (P_LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [P_LOG2_DEPTH:0] COUNT_ONE  = (P_LOG2_DEPTH + 1)'(1);

  typedef enum logic [1:0] {
    S_FILL,
    S_ARM,
    S_RUN_ACK,
    S_RUN_DRAIN
  } state_t;

  logic [SEG_W-1:0]        mem [DEPTH];
  logic [P_LOG2_DEPTH-1:0] wr_ptr;
  logic [P_LOG2_DEPTH-1:0] rd_ptr;
  logic [P_LOG2_DEPTH-1:0] rd_ptr_inc;
  logic [P_LOG2_DEPTH:0]   count;
  logic [P_LOG2_DEPTH:0]   count_next;
  logic                    full_q;
  logic                    empty_q;
  logic                    overflow_q;
  logic [SEG_W-1:0]        head_q;
  logic [SEG_W-1:0]        wdata;
  logic [P_X_COORD_W-1:0]  x0_st;
  logic [P_X_COORD_W-1:0]  x1_st;
  logic [P_Y_COORD_W-1:0]  y0_st;
  logic [P_Y_COORD_W-1:0]  y1_st;
  logic                    push_ok;
  logic                    pop_ok;
  state_t                  state;
  logic                    pending;
  logic                    clear_q;

`ifdef LINE_QUEUE_CLIP_EN
  localparam logic [P_X_COORD_W-1:0] X_MAX = P_X_COORD_W'(P_SCREEN_W - 1);
  localparam logic [P_Y_COORD_W-1:0] Y_MAX = P_Y_COORD_W'(P_SCREEN_H - 1);

  assign x0_st = (i_x0 > X_MAX) ? X_MAX : i_x0;
  assign x1_st = (i_x1 > X_MAX) ? X_MAX : i_x1;
  assign y0_st = (i_y0 > Y_MAX) ? Y_MAX : i_y0;
  assign y1_st = (i_y1 > Y_MAX) ? Y_MAX : i_y1;
`else
  assign x0_st = i_x0;
  assign x1_st = i_x1;
  assign y0_st = i_y0;
  assign y1_st = i_y1;
`endif

  assign wdata      = {x0_st, y0_st, x1_st, y1_st};
  assign pop_ok     = i_pop & ~empty_q;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign push_ok    = i_wr & (~full_q | pop_ok);
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // The head register is loaded one step ahead so the next entry is ready right after a pop.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      count   <= count_next;
      full_q  <= (count_next == COUNT_FULL);
      empty_q <= (count_next == '0);
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (i_wr && full_q && !pop_ok) begin
        overflow_q <= 1'b1;
      end
      if (pop_ok) begin
        if (count == COUNT_ONE) begin
          if (push_ok) begin
            head_q <= wdata;
          end
        end else begin
          head_q <= mem[rd_ptr_inc];
        end
      end else if (empty_q && push_ok) begin
        head_q <= wdata;
      end
    end
  end

  // Frame sequencer: a finished frame arms a clear request, then waits for the engine to drain.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state   <= S_FILL;
      pending <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      if (i_frame_end) begin
        pending <= 1'b1;
      end else if (state == S_ARM && i_draw_waiting) begin
        pending <= 1'b0;
      end
      case (state)
        S_FILL: begin
          if (pending || i_frame_end) begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (i_draw_waiting) begin
            clear_q <= 1'b1;
            state   <= S_RUN_ACK;
          end
        end
        S_RUN_ACK: begin
          if (!i_draw_waiting) begin
            state <= S_RUN_DRAIN;
          end
        end
        S_RUN_DRAIN: begin
          if (i_draw_waiting && empty_q) begin
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_count        = count;
  assign o_overflow     = overflow_q;
  assign o_clear_buffer = clear_q;
  assign o_x0 = head_q[SEG_W-1 -: P_X_COORD_W];
  assign o_y0 = head_q[P_X_COORD_W+2*P_Y_COORD_W-1 -: P_Y_COORD_W];
  assign o_x1 = head_q[P_X_COORD_W+P_Y_COORD_W-1 -: P_X_COORD_W];
  assign o_y1 = head_q[P_Y_COORD_W-1:0];

endmodule

// File: doc/line_queue.md
Name: line_queue

Overview:
- Segment queue and frame sequencer that sits directly upstream of the line-draw engine.
- The projection stage pushes line segments (x0,y0,x1,y1) and marks the end of each frame.
- The block holds the segments in a first-word-fall-through FIFO and tells the draw engine when to clear the screen buffer.
- The draw engine then pops one segment per LOAD cycle until the queue is empty.

Parameters:
- P_X_COORD_W, 11, x coordinate width
- P_Y_COORD_W, 11, y coordinate width
- P_LOG2_DEPTH, 4, log2 of FIFO depth (default depth 16 segments)
- P_SCREEN_W, 640, screen width in pixels (used by the clip option)
- P_SCREEN_H, 480, screen height in pixels (used by the clip option)

Ports:
- i_clk  in  1  clock; the block uses this one clock only
- i_reset_n  in  1  reset, synchronous, active-low
- i_wr  in  1  push the segment on i_x0..i_y1
- i_x0, i_x1  in  P_X_COORD_W each  segment x endpoints
- i_y0, i_y1  in  P_Y_COORD_W each  segment y endpoints
- i_frame_end  in  1  one-cycle pulse: the current frame's segment list is complete
- o_full  out  1  FIFO holds 2^P_LOG2_DEPTH entries
- o_empty  out  1  FIFO holds 0 entries
- o_count  out  P_LOG2_DEPTH+1  number of stored entries
- o_x0, o_x1  out  P_X_COORD_W each  head-of-queue x endpoints
- o_y0, o_y1  out  P_Y_COORD_W each  head-of-queue y endpoints
- i_pop  in  1  draw engine consumes the head entry (its LOAD-state strobe)
- i_draw_waiting  in  1  draw engine is idle
- o_clear_buffer  out  1  one-cycle request to the draw engine to clear and start drawing
- o_overflow  out  1  sticky: a push arrived while the FIFO was full

Behaviour:
- Reset (i_reset_n=0 at a clock edge): pointers and count go to 0; o_empty=1; o_full=0; o_count=0; o_clear_buffer=0; o_overflow=0; o_x*/o_y*=0; FSM goes to FILL; pending-frame flag is cleared. Reset mid-frame discards all stored segments.
- FIFO storage: register array of 2^P_LOG2_DEPTH entries, 2*P_X_COORD_W+2*P_Y_COORD_W bits each.
- Pointers: read and write pointers are P_LOG2_DEPTH bits wide and wrap modulo depth.
- Push: accepted when i_wr=1 and (not full, or i_pop is accepted in the same cycle).
- Push while full without a pop: data is dropped, o_overflow is set to 1 and stays 1 until reset.
- Pop: accepted when i_pop=1 and not empty. Pop while empty is ignored with no flag.
- Simultaneous accepted push and pop: o_count is unchanged, both pointers advance.
- Push into an empty FIFO: the entry appears on o_x*/o_y* in the next cycle, o_empty falls that cycle (1-cycle fall-through latency).
- Head outputs: hold the head entry whenever not empty; after a pop they show the next entry on the next cycle. When empty they hold their last value.
- o_full, o_empty and o_count are registered and consistent with each other in every cycle.
- Pending flag: set by i_frame_end in any state; cleared when the ARM state issues o_clear_buffer.
- FSM state FILL: go to ARM when the pending flag is 1 (or i_frame_end=1 this cycle).
- FSM state ARM: wait for i_draw_waiting=1. On that cycle assert o_clear_buffer for exactly one cycle, clear the pending flag, go to RUN.
- FSM state RUN: first wait for i_draw_waiting=0 (the engine has accepted the request). Then wait for i_draw_waiting=1 and o_empty=1, and go to FILL.
- Pending frames: if the pending flag is set again during RUN, FILL moves straight to ARM on its next cycle. Back-to-back frames therefore need no extra handshake.
- Writes are accepted in every state. Segments pushed during RUN are drawn in the current frame if they arrive before the engine drains the queue.
- o_clear_buffer never asserts in two consecutive cycles.

Optional Feature:
- Macro: LINE_QUEUE_CLIP_EN.
- Defined: on push, each x endpoint >= P_SCREEN_W is stored as P_SCREEN_W-1, and each y endpoint >= P_SCREEN_H is stored as P_SCREEN_H-1. The clamp is combinational before storage and adds no latency.
- Undefined: endpoints are stored unmodified.

Test Plan:
- Reset, push (10,20,30,40), pop: one cycle after the push, o_empty=0, o_count=1, head shows 10,20,30,40. After the pop, o_empty=1 and o_count=0.
- Push 16 distinct segments with no pops: o_full=1 and o_count=16. A 17th push sets o_overflow=1 and the stored contents are unchanged. Sixteen pops return the segments in push order, covering pointer wrap.
- With the FIFO full, i_wr and i_pop asserted in the same cycle: push accepted, o_count stays 16, o_overflow stays 0, the new entry emerges last.
- i_frame_end pulse while i_draw_waiting=0 -> no o_clear_buffer. Raise i_draw_waiting -> exactly one o_clear_buffer pulse. Then i_draw_waiting low, queue drained, i_draw_waiting high -> FSM back in FILL.
- Second i_frame_end during RUN: after the first frame completes, a second o_clear_buffer pulse follows with no further i_frame_end.
- With LINE_QUEUE_CLIP_EN defined, push (700,500,5,5): head reads 639,479,5,5. Without the macro, head reads 700,500,5,5.
